// File: rtl/cp0_regfile_pkg.sv
// ---------------------------------------------------------------------------
// cp0_defs
// Shared definitions for the CP0 register file: register numbers, the bit
// positions of the Status and Cause fields, and the ExcCode values that the
// commit stage records on an exception.
// ---------------------------------------------------------------------------
package cp0_defs;

    // CP0 register numbers (all at select 0)
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    // Status field positions
    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LO  = 8;
    localparam int STATUS_IM_HI  = 15;
    localparam int STATUS_BEV    = 22;

    // Cause field positions
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_EXC_HI  = 6;
    localparam int CAUSE_IP_LO   = 8;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_BD      = 31;

    // Exception codes written into Cause.ExcCode
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

endpackage

// File: rtl/cp0_regfile_timer.sv
// ---------------------------------------------------------------------------
// cp0_timer
// Count/Compare timer. Count advances once every two clocks, paced by an
// internal tick toggle. TI is raised on the edge where Count's next value
// equals Compare and stays set until Compare is written.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   count_we      load Count from wdata (also restarts the tick phase)
//   compare_we    load Compare from wdata (also clears TI)
//   wdata         write data for both registers
//   count_o       current Count
//   compare_o     current Compare
//   ti_o          timer interrupt flag
// ---------------------------------------------------------------------------
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tick_q, tick_d;
    logic        ti_q, ti_d;

    always_comb begin
        count_d   = count_q;
        tick_d    = ~tick_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        if (count_we) begin
            count_d = wdata;
            tick_d  = 1'b0;
        end else if (tick_q) begin
            count_d = count_q + 32'd1;
        end

        // The match is taken against the value Count is about to hold, so a
        // hold cycle that sits on Compare keeps matching; a Compare write wins.
        if (compare_we) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end else if (count_d == compare_q) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            tick_q    <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tick_q    <= tick_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// ---------------------------------------------------------------------------
// cp0_regfile
// Coprocessor-0 register file answering MFC0/MTC0 from the execute stage,
// recording exceptions and ERET from commit, and producing the masked
// interrupt request.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   addr, sel                CP0 register number and select
//   writeData, writeEn       MTC0 data and strobe
//   readData                 MFC0 data (combinational, no side effects)
//   exc_valid, exc_code      exception committed and its ExcCode
//   exc_pc, exc_bd           faulting PC and delay-slot flag
//   exc_badva_we, exc_badva  BadVAddr update for address errors
//   eret                     ERET committed
//   hw_int                   level-sensitive external interrupt lines
//   status_o, cause_o, epc_o current register values
//   int_req                  interrupt pending and enabled
// ---------------------------------------------------------------------------
module cp0_regfile
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h0001_8000,
    parameter logic [31:0] CONFIG_VAL = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  addr,
    input  logic [2:0]  sel,
    input  logic [31:0] writeData,
    input  logic        writeEn,
    output logic [31:0] readData,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        exc_badva_we,
    input  logic [31:0] exc_badva,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        int_req
);

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic        bd_q, bd_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badva_q, badva_d;

    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;

    logic mtc0;
    logic wr_status, wr_cause, wr_epc, wr_count, wr_compare;

    assign mtc0       = writeEn && (sel == 3'd0);
    assign wr_status  = mtc0 && (addr == CP0_STATUS);
    assign wr_cause   = mtc0 && (addr == CP0_CAUSE);
    assign wr_epc     = mtc0 && (addr == CP0_EPC);
    assign wr_count   = mtc0 && (addr == CP0_COUNT);
    assign wr_compare = mtc0 && (addr == CP0_COMPARE);

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr_count),
        .compare_we (wr_compare),
        .wdata      (writeData),
        .count_o    (count),
        .compare_o  (compare),
        .ti_o       (ti)
    );

    // Status is owned by an exception or ERET in the cycle one commits, so a
    // colliding MTC0 Status is dropped whole; likewise an exception owns EPC.
    // Cause.IP[1:0] has no competing writer and always takes the MTC0.
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        ip_sw_d    = ip_sw_q;
        ip_hw_d    = {hw_int[5] | ti, hw_int[4:0]};
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        badva_d    = badva_q;

        if (wr_status && !exc_valid && !eret) begin
            im_d  = writeData[STATUS_IM_HI:STATUS_IM_LO];
            exl_d = writeData[STATUS_EXL];
            ie_d  = writeData[STATUS_IE];
        end
        if (wr_cause) begin
            ip_sw_d = writeData[CAUSE_IP_LO+1:CAUSE_IP_LO];
        end
        if (wr_epc && !exc_valid) begin
            epc_d = writeData;
        end

        if (eret) begin
            exl_d = 1'b0;
        end

        // A nested exception (EXL already set) keeps the original return PC.
        if (exc_valid) begin
            exc_code_d = exc_code;
            exl_d      = 1'b1;
            if (!exl_q) begin
                epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
                bd_d  = exc_bd;
            end
            if (exc_badva_we) begin
                badva_d = exc_badva;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_q       <= 8'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            ip_sw_q    <= 2'd0;
            ip_hw_q    <= 6'd0;
            bd_q       <= 1'b0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
            badva_q    <= 32'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            badva_q    <= badva_d;
        end
    end

    // BEV is hardwired to 1.
    assign status_o = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_o  = {bd_q, ti, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'd0};
    assign epc_o    = epc_q;

    assign int_req = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));

    always_comb begin
        readData = 32'd0;
        if (sel == 3'd0) begin
            case (addr)
                CP0_BADVADDR: readData = badva_q;
                CP0_COUNT:    readData = count;
                CP0_COMPARE:  readData = compare;
                CP0_STATUS:   readData = status_o;
                CP0_CAUSE:    readData = cause_o;
                CP0_EPC:      readData = epc_q;
                CP0_PRID:     readData = PRID_VAL;
                CP0_CONFIG:   readData = CONFIG_VAL;
                default:      readData = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// ---------------------------------------------------------------------------
// tb_cp0_regfile
// Directed bench for cp0_regfile. A field-level model tracks the register
// file's architectural state; Count is kept as "value at last load plus half
// the edges since", not as a counter with a phase bit. Every negative edge
// outside reset compares the DUT outputs and the current MFC0 read against
// the model, and the directed sequence adds hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_cp0_regfile;
    import cp0_defs::*;

    localparam logic [31:0] PRID   = 32'h0001_8000;
    localparam logic [31:0] CONFIG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  addr;
    logic [2:0]  sel;
    logic [31:0] writeData;
    logic        writeEn;
    logic [31:0] readData;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        exc_badva_we;
    logic [31:0] exc_badva;
    logic        eret;
    logic [5:0]  hw_int;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        int_req;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic run_checks = 1'b0;

    cp0_regfile #(
        .PRID_VAL   (PRID),
        .CONFIG_VAL (CONFIG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .sel          (sel),
        .writeData    (writeData),
        .writeEn      (writeEn),
        .readData     (readData),
        .exc_valid    (exc_valid),
        .exc_code     (exc_code),
        .exc_pc       (exc_pc),
        .exc_bd       (exc_bd),
        .exc_badva_we (exc_badva_we),
        .exc_badva    (exc_badva),
        .eret         (eret),
        .hw_int       (hw_int),
        .status_o     (status_o),
        .cause_o      (cause_o),
        .epc_o        (epc_o),
        .int_req      (int_req)
    );

    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [7:0]  m_im;
    logic        m_exl, m_ie;
    logic [1:0]  m_ip_sw;
    logic [5:0]  m_ip_hw;
    logic        m_bd;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_badva, m_compare, m_count_base;
    int          m_edges;
    logic        m_ti;

    function automatic logic [31:0] model_count();
        return m_count_base + 32'(m_edges / 2);
    endfunction

    function automatic logic [31:0] model_status();
        return 32'h0040_0000 + (32'(m_im) << 8) + (32'(m_exl) << 1) + 32'(m_ie);
    endfunction

    function automatic logic [31:0] model_cause();
        return (32'(m_bd) << 31) + (32'(m_ti) << 30) + (32'(m_ip_hw) << 10) +
               (32'(m_ip_sw) << 8) + (32'(m_code) << 2);
    endfunction

    function automatic logic model_int();
        logic [7:0] pend;
        pend = {m_ip_hw, m_ip_sw} & m_im;
        return m_ie && !m_exl && (pend != 8'd0);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic [2:0] s);
        if (s != 3'd0) return 32'd0;
        case (a)
            5'd8:    return m_badva;
            5'd9:    return model_count();
            5'd11:   return m_compare;
            5'd12:   return model_status();
            5'd13:   return model_cause();
            5'd14:   return m_epc;
            5'd15:   return PRID;
            5'd16:   return CONFIG;
            default: return 32'd0;
        endcase
    endfunction

    // Model advances on the same edges as the DUT, from the inputs held
    // across that edge and the model's pre-edge state.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_im = 8'd0; m_exl = 1'b0; m_ie = 1'b0; m_ip_sw = 2'd0; m_ip_hw = 6'd0;
            m_bd = 1'b0; m_code = 5'd0; m_epc = 32'd0; m_badva = 32'd0;
            m_compare = 32'd0; m_count_base = 32'd0; m_edges = 0; m_ti = 1'b0;
        end else begin
            logic        old_exl, old_ti, mt;
            logic [31:0] next_count, old_compare;
            old_exl     = m_exl;
            old_ti      = m_ti;
            old_compare = m_compare;
            mt          = writeEn && (sel == 3'd0);

            if (mt && addr == 5'd9) begin
                m_count_base = writeData;
                m_edges      = 0;
            end else begin
                m_edges = m_edges + 1;
            end
            next_count = model_count();

            if (mt && addr == 5'd11) begin
                m_compare = writeData;
                m_ti      = 1'b0;
            end else if (next_count == old_compare) begin
                m_ti = 1'b1;
            end

            m_ip_hw = {hw_int[5] | old_ti, hw_int[4:0]};

            if (mt && addr == 5'd12 && !exc_valid && !eret) begin
                m_im  = writeData[15:8];
                m_exl = writeData[1];
                m_ie  = writeData[0];
            end
            if (mt && addr == 5'd13) m_ip_sw = writeData[9:8];
            if (mt && addr == 5'd14 && !exc_valid) m_epc = writeData;
            if (eret) m_exl = 1'b0;
            if (exc_valid) begin
                m_code = exc_code;
                m_exl  = 1'b1;
                if (!old_exl) begin
                    m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
                    m_bd  = exc_bd;
                end
                if (exc_badva_we) m_badva = exc_badva;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared = n_compared + 1;
        if (actual !== expected) begin
            n_mismatched = n_mismatched + 1;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_checks && !rst) begin
            checkOutput("status_o", status_o, model_status());
            checkOutput("cause_o", cause_o, model_cause());
            checkOutput("epc_o", epc_o, m_epc);
            checkOutput("int_req", {31'd0, int_req}, {31'd0, model_int()});
            checkOutput("readData", readData, model_read(addr, sel));
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic [4:0] a, input logic we, input logic [31:0] wd,
                                 input logic exv, input logic [4:0] code,
                                 input logic [31:0] pc, input logic bd, input logic er);
        addr = a; sel = 3'd0; writeData = wd; writeEn = we;
        exc_valid = exv; exc_code = code; exc_pc = pc; exc_bd = bd; eret = er;
        @(posedge clk); #1;
        writeEn = 1'b0; exc_valid = 1'b0; eret = 1'b0; exc_badva_we = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] wd);
        applyStimulus(a, 1'b1, wd, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic peek(input string name, input logic [4:0] a, input logic [2:0] s,
                        input logic [31:0] expected);
        addr = a; sel = s; #1;
        checkOutput(name, readData, expected);
        sel = 3'd0;
    endtask

    initial begin
        rst = 1'b1; addr = 5'd0; sel = 3'd0; writeData = 32'd0; writeEn = 1'b0;
        exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0; exc_bd = 1'b0;
        exc_badva_we = 1'b0; exc_badva = 32'd0; eret = 1'b0; hw_int = 6'd0;
        @(posedge clk); #1;
        checkOutput("rst_status_o", status_o, 32'h0040_0000);
        checkOutput("rst_int_req", {31'd0, int_req}, 32'd0);
        checkOutput("rst_epc_o", epc_o, 32'd0);
        peek("rst_status", CP0_STATUS, 3'd0, 32'h0040_0000);
        peek("rst_cause", CP0_CAUSE, 3'd0, 32'd0);
        peek("rst_count", CP0_COUNT, 3'd0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_checks = 1'b1;

        // Count pacing: 10 then six idle edges -> 13
        mtc0(CP0_COUNT, 32'd10);
        idle(6);
        peek("count_13", CP0_COUNT, 3'd0, 32'd13);

        // Compare = Count+2 -> TI three edges after the write
        mtc0(CP0_COMPARE, 32'd15);
        checkOutput("ti_cleared_by_cmp", {31'd0, cause_o[30]}, 32'd0);
        idle(4);
        checkOutput("ti_set", {31'd0, cause_o[30]}, 32'd1);
        mtc0(CP0_COMPARE, 32'h0000_1000);
        checkOutput("ti_clear", {31'd0, cause_o[30]}, 32'd0);

        // IM2 + IE, then hw_int[0]
        mtc0(CP0_STATUS, 32'h0000_0401);
        checkOutput("status_401", status_o, 32'h0040_0401);
        hw_int = 6'b000001;
        idle(2);
        checkOutput("int_hw0", {31'd0, int_req}, 32'd1);
        applyStimulus(5'd0, 1'b0, 32'd0, 1'b1, EXC_INT, 32'h8000_1000, 1'b0, 1'b0);
        checkOutput("int_masked_exl", {31'd0, int_req}, 32'd0);
        checkOutput("epc_int", epc_o, 32'h8000_1000);
        applyStimulus(5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("int_after_eret", {31'd0, int_req}, 32'd1);
        hw_int = 6'd0;
        idle(1);

        // Delay-slot overflow, then a nested address error
        applyStimulus(5'd0, 1'b0, 32'd0, 1'b1, EXC_OV, 32'hBFC0_0100, 1'b1, 1'b0);
        checkOutput("epc_bd", epc_o, 32'hBFC0_00FC);
        checkOutput("cause_bd", {31'd0, cause_o[31]}, 32'd1);
        checkOutput("cause_code_ov", {27'd0, cause_o[6:2]}, 32'd12);
        checkOutput("exl_set", {31'd0, status_o[1]}, 32'd1);
        exc_badva_we = 1'b1; exc_badva = 32'hDEAD_BEEF;
        applyStimulus(5'd0, 1'b0, 32'd0, 1'b1, EXC_ADEL, 32'h1234_5678, 1'b0, 1'b0);
        checkOutput("epc_nested_hold", epc_o, 32'hBFC0_00FC);
        checkOutput("bd_nested_hold", {31'd0, cause_o[31]}, 32'd1);
        checkOutput("cause_code_adel", {27'd0, cause_o[6:2]}, 32'd4);
        peek("badvaddr", CP0_BADVADDR, 3'd0, 32'hDEAD_BEEF);

        // exc + eret + MTC0 Status=0 together, then eret alone
        applyStimulus(CP0_STATUS, 1'b1, 32'd0, 1'b1, EXC_SYS, 32'h0000_2000, 1'b0, 1'b1);
        checkOutput("triple_status", status_o, 32'h0040_0403);
        applyStimulus(5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("eret_status", status_o, 32'h0040_0401);

        // Write-mask on Status, then software interrupts
        mtc0(CP0_STATUS, 32'hFFFF_FFFF);
        checkOutput("status_mask", status_o, 32'h0040_FF03);
        mtc0(CP0_STATUS, 32'h0000_0301);
        checkOutput("int_sw_before", {31'd0, int_req}, 32'd0);
        mtc0(CP0_CAUSE, 32'h0000_0300);
        checkOutput("cause_ip_sw", {30'd0, cause_o[9:8]}, 32'd3);
        checkOutput("int_sw", {31'd0, int_req}, 32'd1);

        // Read-only and unmapped registers
        mtc0(CP0_PRID, 32'h0000_1234);
        peek("prid", CP0_PRID, 3'd0, 32'h0001_8000);
        mtc0(CP0_BADVADDR, 32'd0);
        peek("badvaddr_ro", CP0_BADVADDR, 3'd0, 32'hDEAD_BEEF);
        peek("config", CP0_CONFIG, 3'd0, 32'h8000_0000);
        peek("sel1", CP0_STATUS, 3'd1, 32'd0);
        peek("unmapped", 5'd3, 3'd0, 32'd0);

        // Count wrap against Compare = 0
        mtc0(CP0_COMPARE, 32'd0);
        mtc0(CP0_COUNT, 32'hFFFF_FFFF);
        idle(1);
        peek("count_ffff", CP0_COUNT, 3'd0, 32'hFFFF_FFFF);
        idle(1);
        peek("count_wrap", CP0_COUNT, 3'd0, 32'd0);
        checkOutput("ti_wrap", {31'd0, cause_o[30]}, 32'd1);

        // Reset mid-write discards the write
        addr = CP0_EPC; writeData = 32'hCAFE_0000; writeEn = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        writeEn = 1'b0;
        checkOutput("rst_mid_epc", epc_o, 32'd0);
        checkOutput("rst_mid_status", status_o, 32'h0040_0000);
        rst = 1'b0;
        idle(3);
        checkOutput("post_rst_epc", epc_o, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file: the responder end of the CP0 read/write interface driven by the execute-stage ALU's MFC0/MTC0 micro-ops. Holds BadVAddr, Count, Compare, Status, Cause, EPC, PRId and Config. Runs the Count/Compare timer and accepts exception and ERET events from commit. Produces the masked interrupt request consumed by the commit/exception logic.

## Interface
Parameters:
- PRID_VAL, 32'h0001_8000, constant returned for PRId (reg 15, sel 0)
- CONFIG_VAL, 32'h8000_0000, constant returned for Config (reg 16, sel 0)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- addr  in  5  CP0 register number (CP0WRInterface resp side)
- sel  in  3  CP0 select
- writeData  in  32  MTC0 data
- writeEn  in  1  MTC0 strobe
- readData  out  32  MFC0 data, combinational
- exc_valid  in  1  exception committed this cycle
- exc_code  in  5  Cause.ExcCode to record
- exc_pc  in  32  PC of faulting instruction
- exc_bd  in  1  faulting instruction is in a delay slot
- exc_badva_we  in  1  update BadVAddr (AdEL/AdES)
- exc_badva  in  32  faulting address
- eret  in  1  ERET committed this cycle
- hw_int  in  6  external interrupt lines, level-sensitive
- status_o, cause_o, epc_o  out  32 each  current register values
- int_req  out  1  interrupt pending and enabled

## Operation
- Read: readData = selected register's current value; sel≠0 or unmapped addr -> 0. No side effects.
- Write (writeEn, sel=0) takes effect at next edge; same-cycle read returns old value.
- Writable fields: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; EPC, Count, Compare full 32 bits. Writes to BadVAddr, PRId, Config, Status BEV[22] and other bits ignored. BEV is hardwired 1.
- Count increments by 1 every second cycle via an internal tick toggle. A Count write loads writeData and clears the toggle.
- Compare write loads writeData and clears the timer flag TI (Cause[30]).
- TI is set on the edge where Count's next value equals Compare, and is sticky until a Compare write.
- Cause IP[15:10] = {hw_int[5] | TI, hw_int[4:0]}, registered each cycle.
- Exception (exc_valid):
  - Cause.ExcCode <= exc_code.
  - If Status.EXL was 0: EPC <= exc_bd ? exc_pc−4 : exc_pc, and Cause.BD <= exc_bd. Otherwise EPC and BD hold.
  - EXL <= 1.
  - BadVAddr <= exc_badva when exc_badva_we.
- ERET: EXL <= 0.
- Same-cycle priority: exc_valid > eret > MTC0 for any field both touch. Non-conflicting MTC0 fields (e.g. Compare) still write. Count increments unless Count itself is written.
- int_req = IE & ~EXL & |(Cause.IP[15:8] & Status.IM[15:8]), combinational from registered state.

## Timing
- Reset (async, immediate): Status = 32'h0040_0000, Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 0, tick = 0, TI = 0.
  - Hence readData = 0 for reset-valued registers, int_req = 0, status_o = 32'h0040_0000.
- Latency:
  - MFC0 is 0 cycles.
  - MTC0, exception and ERET are visible on the cycle after the strobe.
  - hw_int reaches Cause.IP and int_req 1 cycle later.
- Count wraps 32'hFFFF_FFFF -> 0 with no flag. Compare = 0 still matches after wrap.
- Reset asserted mid-operation discards any same-cycle write or exception.

## Structure
- Shared package cp0_defs:
  - register number constants (CP0_BADVADDR=8, COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14, PRID=15, CONFIG=16)
  - Status/Cause field bit positions
  - ExcCode enum (Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12)
- Sub-module cp0_timer holds Count, tick, Compare and TI. Interface: count/compare write strobes and data, count_o, compare_o, ti_o.

## Test plan
- Reset, then read Status, Cause, Count -> 32'h0040_0000, 0, 0; int_req = 0.
- Write Count=10 and hold idle 6 cycles -> Count reads 13. Write Compare=Count+2, wait -> TI and Cause[30] set; rewrite Compare -> TI cleared next cycle.
- Write Status=32'h0000_0401 (IM2, IE) and raise hw_int[0] -> int_req = 1 two cycles later. Set EXL via exception -> int_req = 0.
- exc_valid with exc_pc=32'hBFC0_0100, exc_bd=1, code=Ov -> EPC = 32'hBFC0_00FC, BD = 1, ExcCode = 12, EXL = 1. A second exception while EXL=1 leaves EPC unchanged.
- exc_valid, eret and MTC0 Status=0 in the same cycle -> EXL = 1 and IE unchanged. eret alone -> EXL = 0.
- MTC0 Cause with IP[1:0]=2'b11 and IM[9:8] set -> int_req = 1. Write to PRId ignored; reads PRID_VAL. sel=1 reads 0.
